// File: rtl/t_ff_counter.sv
// t_ff_counter: WIDTH-bit register built from T-flip-flop toggle logic.
// Supports mod-MODULUS up/down counting, parallel load, a raw per-bit toggle
// mode, a registered terminal-count pulse and a sticky range-error flag.
// The next value is computed as a target state, then turned into a per-bit
// toggle vector that drives the bank of T flip-flops.
module t_ff_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             err
);

    // Reject illegal moduli at elaboration time.
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("t_ff_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end

    // One extra bit so MODULUS == 2**WIDTH is representable in compares.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_TOG  = 2'b11;

    logic [WIDTH-1:0] nxt_q;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] raw_v;
    logic             nxt_tc;
    logic             nxt_err;

    assign raw_v = q ^ t;

    // Next-state selection: load beats enabled counting, which beats hold.
    always_comb begin
        nxt_q   = q;
        nxt_tc  = 1'b0;
        nxt_err = err;
        if (load) begin
            if ({1'b0, d} < MOD_EXT) begin
                nxt_q = d;
            end else begin
                nxt_q   = MAX_VAL;
                nxt_err = 1'b1;
            end
        end else if (en) begin
            case (mode)
                MODE_UP: begin
                    if (q == MAX_VAL) begin
                        nxt_q  = '0;
                        nxt_tc = 1'b1;
                    end else begin
                        nxt_q = q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (q == '0) begin
                        nxt_q  = MAX_VAL;
                        nxt_tc = 1'b1;
                    end else begin
                        nxt_q = q - WIDTH'(1);
                    end
                end
                MODE_TOG: begin
                    if ({1'b0, raw_v} < MOD_EXT) begin
                        nxt_q = raw_v;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
                MODE_HOLD: begin
                    nxt_q = q;
                end
                default: begin
                    nxt_q = q;
                end
            endcase
        end
    end

    // Bits that must flip to reach the target state feed the T inputs.
    assign tog = q ^ nxt_q;

    // T flip-flop bank plus registered tc and sticky err; async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            tc  <= 1'b0;
            err <= 1'b0;
        end else begin
            q   <= q ^ tog;
            tc  <= nxt_tc;
            err <= nxt_err;
        end
    end

    assign qbar = ~q;

endmodule

// File: doc/t_ff_counter.md
Name: t_ff_counter

Overview:
- Parametrised N-bit register built from T-flip-flop toggle logic.
- Generalises the single T flip-flop to a WIDTH-bit bank with mod-N counting, direction control, parallel load, raw per-bit toggle mode, terminal-count pulse and sticky error flag.
- Used as the common counter/divider primitive for lab timing blocks, e.g. BCD digit counters and clock-enable dividers.

Parameters:
- WIDTH, 4, bit width of the register.
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2..2**WIDTH; elaboration fails outside it.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count/toggle enable; does not gate load.
- load  input  1  synchronous parallel load, highest synchronous priority.
- d  input  WIDTH  load value.
- mode  input  2  00 hold, 01 count up, 10 count down, 11 raw toggle.
- t  input  WIDTH  per-bit toggle vector, used only in mode 11.
- q  output  WIDTH  register state.
- qbar  output  WIDTH  bitwise complement of q, always ~q.
- tc  output  1  registered terminal-count pulse.
- err  output  1  sticky range error.

Behaviour:
- Reset: rst high asynchronously forces q=0, qbar=all ones, tc=0, err=0, regardless of clk. Reset asserted mid-count aborts immediately. First update after release happens on the first rising clk edge with rst low.
- Priority at each rising edge: rst > load > (en and mode) > hold.
- Load (load=1):
  - If d < MODULUS: q<=d.
  - Else: q<=MODULUS-1 and err<=1.
  - Load takes effect whatever en and mode are.
  - tc<=0.
  - A legal load does not clear err.
- en=0 and load=0: q holds; tc<=0.
- Mode 00: q holds; tc<=0.
- Mode 01 (up):
  - If q==MODULUS-1: q<=0 and tc<=1.
  - Else: q<=q+1 and tc<=0.
- Mode 10 (down):
  - If q==0: q<=MODULUS-1 and tc<=1.
  - Else: q<=q-1 and tc<=0.
- Mode 11 (raw toggle), next value v = q XOR t:
  - If v < MODULUS: q<=v.
  - Else: q holds and err<=1.
  - tc<=0 in both cases. t=0 behaves as hold.
- tc latency: high for exactly one cycle, the cycle after the wrapping edge, aligned with the wrapped q value. Continuous counting gives one tc every MODULUS enabled cycles.
- Direction change: takes effect on the same edge. A mode switch at a boundary is evaluated against the new mode only.
- Power-of-two MODULUS (MODULUS=2**WIDTH): natural wrap. err can never be set by mode 11 or load.
- err: cleared only by rst.
- No combinational path from inputs to q, tc or err. qbar is derived from q only.

Test Plan:
- WIDTH=4, MODULUS=10. rst=1 for 12ns, then en=1, mode=01, 12 clocks -> q runs 1..9,0,1,2; tc high only in the cycle q=0; qbar==~q throughout.
- mode=10 from q=0, 3 clocks -> q=9,8,7; tc high only with q=9. Then en=0 for 4 clocks -> q stays 7, tc=0.
- load=1, d=5, en=1, mode=01 on the same edge -> q=5 (load wins), err=0. Next: load=1, d=12 -> q=9, err=1. Later legal load d=3 -> q=3, err stays 1.
- mode=11 from q=3: t=4'b0101 -> q=6. Then t=4'b1010 (v=12) -> q stays 6, err=1.
- Assert rst asynchronously at 3ns after an edge during up-count at q=8 -> q=0, tc=0, err=0 before the next clk edge. Counting resumes 1,2,... after release.
- WIDTH=3, MODULUS=8, mode=01, 9 clocks -> full 0..7 wrap, single tc, err never asserted.
